// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy state encoding.
package pipe_stage_elastic_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with 2-entry skid buffer, registered in_ready and flush.
// Define PIPE_STAGE_PERF_EN to enable the saturating stall/bubble performance counters.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_bubble_cnt
);

    occ_e              state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              accept, consume;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (accept) begin
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                    state_d     = ST_TWO;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A flushed stage drops everything, including this cycle's incoming entry.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready = in_ready_q;
    // Gate ctrl so downstream never sees a stale regWrite/memWrite on a bubble.
    assign out_ctrl = out_valid ? main_ctrl_q : '0;
    assign out_data = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clear(reset),
        .inc  (out_valid & ~out_ready),
        .cnt  (perf_stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .clear(reset),
        .inc  (~out_valid),
        .cnt  (perf_bubble_cnt)
    );
`else
    assign perf_stall_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif

endmodule
